// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Next-PC mode encodings, PC step and immediate sign extension.
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    BEQ  = 3'd1,
    BNE  = 3'd2,
    J    = 3'd3,
    JAL  = 3'd4,
    JR   = 3'd5,
    LOAD = 3'd6
  } mode_t;

  localparam int PC_STEP = 4;

  // Callers cast the result down to their own PC width.
  function automatic logic [63:0] sext16(
    input logic [15:0] v
  );
    return {{48{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; when full, a push
// overwrites the oldest entry and the count saturates.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    cnt;

  assign wptr  = ptr + PW'(1);
  assign top   = mem[ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= wptr;
      if (!full)
        cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with next-PC mux, RAS, exceptions
// and misaligned-target trapping.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [63:0] RESET_VEC = 64'h0,
  parameter logic [63:0] EXC_VEC   = 64'h80,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       mode,
  input  logic             zero,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [WIDTH-1:0] load_val,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             addr_err,
  output logic             ras_miss,
  output logic             ras_ovf,
  output logic             ras_empty
);

  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EV = WIDTH'(EXC_VEC);

  logic [WIDTH-1:0] off;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ras_top;
  logic             ras_full;
  logic             is_beq, is_bne, is_j;
  logic             is_jal, is_jr, is_ld;
  logic             mis, miss_n, adv;
  logic             push, pop;

  assign pc_plus4 = pc + WIDTH'(PC_STEP);
  assign off      = WIDTH'(sext16(imm16));
  assign br_tgt   = pc_plus4 + (off << 2);
  assign j_tgt    = {pc_plus4[WIDTH-1:28],
                     imm26, 2'b00};

  assign is_beq = (mode == BEQ);
  assign is_bne = (mode == BNE);
  assign is_j   = (mode == J);
  assign is_jal = (mode == JAL);
  assign is_jr  = (mode == JR);
  assign is_ld  = (mode == LOAD);

  assign mis =
    (is_jr && (reg_target[1:0] != 2'b00)) ||
    (is_ld && (load_val[1:0] != 2'b00));

  // A trapped JR still consumes its RAS entry.
  assign miss_n = is_jr && !mis &&
    (ras_empty || (ras_top != reg_target));

  assign adv  = !reset && !exc && !stall;
  assign push = adv && is_jal;
  assign pop  = adv && is_jr;

  always_comb begin
    nxt = pc_plus4;
    unique case (1'b1)
      is_beq:         if (zero) nxt = br_tgt;
      is_bne:         if (!zero) nxt = br_tgt;
      is_j, is_jal:   nxt = j_tgt;
      is_jr:          nxt = reg_target;
      is_ld:          nxt = load_val;
      default:        nxt = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RV;
      epc      <= '0;
      addr_err <= 1'b0;
      ras_miss <= 1'b0;
    end else if (exc) begin
      pc       <= EV;
      epc      <= pc;
      addr_err <= 1'b0;
      ras_miss <= 1'b0;
    end else if (stall) begin
      addr_err <= 1'b0;
      ras_miss <= 1'b0;
    end else begin
      pc       <= mis ? EV : nxt;
      addr_err <= mis;
      ras_miss <= miss_n;
      if (mis)
        epc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ras_ovf <= 1'b0;
    else if (push && ras_full)
      ras_ovf <= 1'b1;
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based
// reference model checked on every cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        zero = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] reg_target = '0;
  logic [31:0] load_val = '0;
  logic        exc = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic        addr_err, ras_miss;
  logic        ras_ovf, ras_empty;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_ae, m_miss, m_ovf;
  logic [31:0] m_ras[$];
  bit          chk_en = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH     (32),
    .RESET_VEC (64'h400),
    .EXC_VEC   (64'h80),
    .RAS_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .mode       (mode),
    .zero       (zero),
    .imm16      (imm16),
    .imm26      (imm26),
    .reg_target (reg_target),
    .load_val   (load_val),
    .exc        (exc),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .epc        (epc),
    .addr_err   (addr_err),
    .ras_miss   (ras_miss),
    .ras_ovf    (ras_ovf),
    .ras_empty  (ras_empty)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // Model: next state from the architectural rules.
  task automatic cyc();
    logic [31:0] npc, nepc, p4, tgt;
    logic        nae, nmiss, novf;
    logic [31:0] q[$];
    bit          mis;
    q = m_ras;
    npc = m_pc;
    nepc = m_epc;
    nae = 0;
    nmiss = 0;
    novf = m_ovf;
    mis = 0;
    p4 = m_pc + 32'd4;
    if (reset) begin
      npc = 32'h400;
      nepc = 0;
      q = {};
      novf = 0;
    end else if (exc) begin
      npc = 32'h80;
      nepc = m_pc;
    end else if (!stall) begin
      case (mode)
        3'd1: npc = zero ?
          p4 + 32'(int'($signed(imm16)) * 4) : p4;
        3'd2: npc = !zero ?
          p4 + 32'(int'($signed(imm16)) * 4) : p4;
        3'd3: npc = (p4 & 32'hF000_0000) |
                    (32'(imm26) * 4);
        3'd4: begin
          npc = (p4 & 32'hF000_0000) |
                (32'(imm26) * 4);
          if (q.size() == 4) begin
            void'(q.pop_front());
            novf = 1;
          end
          q.push_back(p4);
        end
        3'd5: begin
          tgt = reg_target;
          mis = (tgt % 4) != 0;
          if (q.size() == 0)
            nmiss = !mis;
          else begin
            nmiss = !mis && (q[$] != tgt);
            void'(q.pop_back());
          end
          npc = tgt;
        end
        3'd6: begin
          npc = load_val;
          mis = (load_val % 4) != 0;
        end
        default: npc = p4;
      endcase
      if (mis) begin
        npc = 32'h80;
        nepc = m_pc;
        nae = 1;
        nmiss = 0;
      end
    end
    @(posedge clk);
    m_pc = npc;
    m_epc = nepc;
    m_ae = nae;
    m_miss = nmiss;
    m_ovf = novf;
    m_ras = q;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("epc", epc, m_epc);
      chk("addr_err", 32'(addr_err), 32'(m_ae));
      chk("ras_miss", 32'(ras_miss), 32'(m_miss));
      chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
      chk("ras_empty", 32'(ras_empty),
          32'(m_ras.size() == 0));
    end
  end

  task automatic go(input logic [2:0] md);
    mode = md;
    cyc();
  endtask

  task automatic ld(input logic [31:0] v);
    load_val = v;
    go(3'd6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra [5];
    ra[0] = 32'h2004;
    ra[1] = 32'h404;
    ra[2] = 32'h804;
    ra[3] = 32'hC04;
    ra[4] = 32'h1004;

    reset = 1;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_pc", pc, 32'h400);
    chk("rst_epc", epc, 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    reset = 0;
    go(3'd0);
    chk("seq1", pc, 32'h404);
    go(3'd0);
    chk("seq2", pc, 32'h408);
    go(3'd0);
    chk("seq3", pc, 32'h40C);

    ld(32'h1000);
    zero = 1;
    imm16 = 16'hFFFE;
    go(3'd1);
    chk("beq_back", pc, 32'hFFC);
    ld(32'h1000);
    imm16 = 16'd5;
    go(3'd2);
    chk("bne_nt", pc, 32'h1004);
    zero = 0;
    go(3'd2);
    chk("bne_t", pc, 32'h101C);

    ld(32'h1000_0010);
    imm26 = 26'h40;
    go(3'd4);
    chk("jal", pc, 32'h1000_0100);
    reg_target = 32'h1000_0014;
    go(3'd5);
    chk("jr", pc, 32'h1000_0014);
    chk("jr_miss", 32'(ras_miss), 32'd0);

    ld(32'h2000);
    for (int k = 1; k <= 5; k++) begin
      imm26 = 26'(k * 32'h100);
      go(3'd4);
    end
    chk("ovf", 32'(ras_ovf), 32'd1);
    for (int k = 4; k >= 1; k--) begin
      reg_target = ra[k];
      go(3'd5);
      chk("jr_hit", 32'(ras_miss), 32'd0);
    end
    reg_target = ra[0];
    go(3'd5);
    chk("jr5_miss", 32'(ras_miss), 32'd1);
    chk("jr5_empty", 32'(ras_empty), 32'd1);

    ld(32'h300);
    ld(32'h2002);
    chk("mis_pc", pc, 32'h80);
    chk("mis_epc", epc, 32'h300);
    chk("mis_ae", 32'(addr_err), 32'd1);
    go(3'd0);
    chk("ae_pulse", 32'(addr_err), 32'd0);

    ld(32'h500);
    stall = 1;
    imm26 = 26'h123;
    go(3'd3);
    chk("stall_pc", pc, 32'h500);
    exc = 1;
    go(3'd3);
    chk("exc_pc", pc, 32'h80);
    chk("exc_epc", epc, 32'h500);
    exc = 0;
    stall = 0;

    imm26 = 26'h10;
    go(3'd4);
    reg_target = 32'h46;
    go(3'd5);
    chk("jr_mis_pc", pc, 32'h80);
    chk("jr_mis_pop", 32'(ras_empty), 32'd1);

    ld(32'hFFFF_FFFC);
    go(3'd7);
    chk("wrap", pc, 32'h0);

    go(3'd4);
    stall = 1;
    reset = 1;
    cyc();
    chk("rst_stall_pc", pc, 32'h400);
    chk("rst_ras", 32'(ras_empty), 32'd1);
    reset = 0;
    stall = 0;
    go(3'd0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter and next-PC sequencer for the MIPS datapath, generalising the fixed 32-bit PC. Adds width and reset/exception vector parameters, signed branch offsets, BEQ/BNE, JAL/JR with a return-address stack (RAS), stall, exceptions with EPC capture, and misaligned-target trapping. It feeds the instruction memory address and the link value back to the register file.

## Interface
- WIDTH, 32: PC width; legal range 32..64.
- RESET_VEC, 0: PC value after reset.
- EXC_VEC, 'h80: PC loaded on exception or address error.
- RAS_DEPTH, 4: RAS entries; power of two, at least 2.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all state this cycle.
- mode  in  3  next-PC select: SEQ, BEQ, BNE, J, JAL, JR, LOAD.
- zero  in  1  ALU zero flag, used by BEQ/BNE.
- imm16  in  16  branch word offset, signed.
- imm26  in  26  jump word index.
- reg_target  in  WIDTH  rs value for JR.
- load_val  in  WIDTH  direct load value.
- exc  in  1  exception request.
- pc  out  WIDTH  current PC, registered.
- pc_plus4  out  WIDTH  pc+4, combinational; also the link value.
- epc  out  WIDTH  faulting PC, registered.
- addr_err  out  1  one-cycle pulse on a misaligned JR/LOAD target.
- ras_miss  out  1  one-cycle pulse when a JR target ≠ RAS top, or the RAS is empty.
- ras_ovf  out  1  sticky; set when JAL pushes onto a full RAS.
- ras_empty  out  1  RAS holds no entries.

## Operation
- Priority each cycle: reset > exc > stall > mode.
- reset:
  - pc=RESET_VEC, epc=0.
  - RAS count=0, ras_ovf=0, pulses 0.
- exc: pc←EXC_VEC, epc←pc. RAS unchanged. Taken even when stall=1.
- stall: pc, epc and RAS hold; pulses deassert.
- SEQ: pc←pc+4.
- BEQ: if zero, pc←pc+4+(sext(imm16)<<2); otherwise pc+4.
- BNE: same target when !zero.
- J: pc←{pc_plus4[WIDTH-1:28], imm26, 2'b00}.
- JAL: same target as J; push pc_plus4 onto the RAS.
  - Full RAS: overwrite the oldest entry (circular), set ras_ovf, count stays RAS_DEPTH.
- JR: pc←reg_target (architectural, never predicted). Pop the RAS.
  - ras_miss←(empty or top≠reg_target).
  - Pop on empty leaves count 0.
- LOAD: pc←load_val; RAS untouched.
- Misaligned JR/LOAD target (bits [1:0]≠0): handle as an exception.
  - pc←EXC_VEC, epc←pc, addr_err pulses.
  - JR still pops the RAS; ras_miss is not asserted.
- Arithmetic: modulo 2^WIDTH; pc+4 at all-ones wraps to 0 silently.
- Undefined mode encodings behave as SEQ.

## Timing
- One-cycle latency: controls sampled at edge N take effect on pc after edge N.
- pc_plus4 follows pc combinationally in the same cycle.
- addr_err and ras_miss are registered: high for exactly the one cycle after the causing edge.
- epc updates on the same edge as pc←EXC_VEC.
- JAL then JR on consecutive cycles: the JR compares against the just-pushed entry.
- Reset mid-stall or mid-exception: reset wins and clears the RAS.
- pc[1:0] is 0 whenever RESET_VEC and EXC_VEC are aligned.

## Structure
- Package pc_pkg holds:
  - typedef enum mode_t: SEQ=0, BEQ=1, BNE=2, J=3, JAL=4, JR=5, LOAD=6.
  - constant PC_STEP=4.
  - helper function sext16 (sign-extend imm16 to WIDTH).
- Sub-module ras_stack (params WIDTH, DEPTH):
  - circular buffer, top pointer, count.
  - push/pop/top/empty/full; simultaneous push+pop is not required.
- pc_sequencer contains the next-PC mux, exception/alignment logic and the pc/epc registers.

## Test plan
- Reset with RESET_VEC=0x400 held 2 cycles, then SEQ for 3 cycles -> pc 0x400, 0x404, 0x408, 0x40C.
- pc=0x1000, BEQ, zero=1, imm16=0xFFFE -> pc=0xFFC. BNE, zero=1, imm16=5 -> pc=0x1004.
- pc=0x1000_0010, JAL, imm26=0x40 -> pc=0x1000_0100. Next cycle JR, reg_target=0x1000_0014 -> pc=0x1000_0014, ras_miss=0.
- RAS_DEPTH=4: 5 JALs then 5 JRs with the matching targets -> ras_ovf=1.
  - First 4 JRs: ras_miss=0.
  - 5th JR: ras_miss=1, ras_empty=1.
- LOAD with load_val=0x2002 at pc=0x300 -> pc=EXC_VEC, epc=0x300, addr_err pulses 1 cycle.
- stall=1 with mode=J -> pc held. Then exc=1 with stall=1 at pc=0x500 -> pc=0x80, epc=0x500.
